// File: rtl/arbitro_escrita_banco_pkg.sv
// arbitro_escrita_banco_pkg: shared FSM state type and default widths for the write arbiter
package arbitro_escrita_banco_pkg;
  localparam int LARGURA_DADO_PAD = 8;
  localparam int LARGURA_END_PAD  = 2;
  typedef enum logic [1:0] {OCIOSO, ESCREVE_A, ESCREVE_B} estado_t;
endpackage

// File: rtl/arbitro_escrita_banco_buffer_requisicao.sv
// buffer_requisicao: one-entry holding buffer for a single write requester
module buffer_requisicao
  import arbitro_escrita_banco_pkg::*;
#(
  parameter int LARGURA_DADO = LARGURA_DADO_PAD,
  parameter int LARGURA_END  = LARGURA_END_PAD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_i,
  input  logic                    limpa_i,
  input  logic [LARGURA_END-1:0]  end_i,
  input  logic [LARGURA_DADO-1:0] dado_i,
  output logic                    pronto_o,
  output logic                    cheio_o,
  output logic [LARGURA_END-1:0]  end_o,
  output logic [LARGURA_DADO-1:0] dado_o
);
  logic                    cheio_q, cheio_d, carrega;
  logic [LARGURA_END-1:0]  end_q;
  logic [LARGURA_DADO-1:0] dado_q;
  // a full buffer refuses new data, so a load and a grant never share an edge
  assign pronto_o = reset & ~cheio_q;
  assign carrega  = req_i & pronto_o;
  assign cheio_d  = carrega | (cheio_q & ~limpa_i);
  assign cheio_o  = cheio_q;
  assign end_o    = end_q;
  assign dado_o   = dado_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cheio_q <= 1'b0;
      end_q   <= '0;
      dado_q  <= '0;
    end else begin
      cheio_q <= cheio_d;
      if (carrega) begin
        end_q  <= end_i;
        dado_q <= dado_i;
      end
    end
  end
endmodule

// File: rtl/arbitro_escrita_banco.sv
// arbitro_escrita_banco: arbitrates ALU and load writebacks onto one register-bank write port
// Define ARB_RODIZIO_EN for round-robin conflict grants; otherwise requester A has fixed priority.
module arbitro_escrita_banco
  import arbitro_escrita_banco_pkg::*;
#(
  parameter int LARGURA_DADO = LARGURA_DADO_PAD,
  parameter int LARGURA_END  = LARGURA_END_PAD
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_a,
  input  logic                        req_b,
  input  logic [LARGURA_END-1:0]      end_a,
  input  logic [LARGURA_END-1:0]      end_b,
  input  logic [LARGURA_DADO-1:0]     dado_a,
  input  logic [LARGURA_DADO-1:0]     dado_b,
  output logic                        pronto_a,
  output logic                        pronto_b,
  output logic                        habilita_escrita,
  output logic [LARGURA_END-1:0]      endereco_escrita,
  output logic [LARGURA_DADO-1:0]     dado_escrita,
  output logic [2**LARGURA_END-1:0]   pendente
);
  estado_t                 estado_q, estado_d;
  logic                    cheio_a, cheio_b, limpa_a, limpa_b, ocupado, vence_b;
  logic [LARGURA_END-1:0]  end_a_q, end_b_q, end_q, end_d;
  logic [LARGURA_DADO-1:0] dado_a_q, dado_b_q, dado_q, dado_d;
`ifdef ARB_RODIZIO_EN
  logic                    rr_q, rr_d;
`endif

  buffer_requisicao #(.LARGURA_DADO(LARGURA_DADO), .LARGURA_END(LARGURA_END)) u_buf_a (
    .clk(clk), .reset(reset), .req_i(req_a), .limpa_i(limpa_a), .end_i(end_a), .dado_i(dado_a),
    .pronto_o(pronto_a), .cheio_o(cheio_a), .end_o(end_a_q), .dado_o(dado_a_q));
  buffer_requisicao #(.LARGURA_DADO(LARGURA_DADO), .LARGURA_END(LARGURA_END)) u_buf_b (
    .clk(clk), .reset(reset), .req_i(req_b), .limpa_i(limpa_b), .end_i(end_b), .dado_i(dado_b),
    .pronto_o(pronto_b), .cheio_o(cheio_b), .end_o(end_b_q), .dado_o(dado_b_q));

  always_comb begin
    ocupado  = cheio_a | cheio_b;
`ifdef ARB_RODIZIO_EN
    vence_b  = (cheio_a & cheio_b) ? rr_q : cheio_b;
    rr_d     = (cheio_a & cheio_b) ? ~rr_q : rr_q;
`else
    vence_b  = cheio_b & ~cheio_a;
`endif
    estado_d = ocupado ? (vence_b ? ESCREVE_B : ESCREVE_A) : OCIOSO;
    end_d    = ocupado ? (vence_b ? end_b_q : end_a_q) : end_q;
    dado_d   = ocupado ? (vence_b ? dado_b_q : dado_a_q) : dado_q;
    limpa_a  = ocupado & ~vence_b;
    limpa_b  = ocupado & vence_b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      end_q    <= '0;
      dado_q   <= '0;
`ifdef ARB_RODIZIO_EN
      rr_q     <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      end_q    <= end_d;
      dado_q   <= dado_d;
`ifdef ARB_RODIZIO_EN
      rr_q     <= rr_d;
`endif
    end
  end

  assign habilita_escrita = (estado_q != OCIOSO);
  assign endereco_escrita = end_q;
  assign dado_escrita     = dado_q;

  // stall flags cover both buffered writes and the one currently on the bank port
  always_comb begin
    pendente = '0;
    if (cheio_a) pendente[end_a_q] = 1'b1;
    if (cheio_b) pendente[end_b_q] = 1'b1;
    if (habilita_escrita) pendente[end_q] = 1'b1;
  end
endmodule

// File: tb/tb_arbitro_escrita_banco.sv
// tb_arbitro_escrita_banco: directed self-checking bench with a register-bank model on the write port
module tb_arbitro_escrita_banco;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [1:0] end_a = '0, end_b = '0;
  logic [7:0] dado_a = '0, dado_b = '0;
  logic       pronto_a, pronto_b, habilita_escrita;
  logic [1:0] endereco_escrita;
  logic [7:0] dado_escrita;
  logic [3:0] pendente;
  logic [7:0] banco [4] = '{default: 8'h00};
  logic [7:0] wr_log [64];
  int         wr_n = 0;
  int         checks = 0, errors = 0;
  logic [7:0] d;
  int         base;

  arbitro_escrita_banco dut (
    .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
    .end_a(end_a), .end_b(end_b), .dado_a(dado_a), .dado_b(dado_b),
    .pronto_a(pronto_a), .pronto_b(pronto_b), .habilita_escrita(habilita_escrita),
    .endereco_escrita(endereco_escrita), .dado_escrita(dado_escrita), .pendente(pendente));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (habilita_escrita) begin
      banco[endereco_escrita] <= dado_escrita;
      wr_log[wr_n[5:0]] <= dado_escrita;
      wr_n <= wr_n + 1;
    end
  end

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic passo();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    confere("rst_hab", habilita_escrita, 0);
    confere("rst_pend", pendente, 0);
    confere("rst_pronto_a", pronto_a, 0);
    confere("rst_pronto_b", pronto_b, 0);
    confere("rst_end", endereco_escrita, 0);
    confere("rst_dado", dado_escrita, 0);
    passo();
    reset = 1'b1;
    #1;
    confere("pronto_a_pos_rst", pronto_a, 1);
    confere("pronto_b_pos_rst", pronto_b, 1);

    // single write of A: r2 <= 3C
    req_a = 1'b1; end_a = 2'd2; dado_a = 8'h3C;
    passo();
    req_a = 1'b0;
    confere("t1_pend_n", pendente, 4'b0100);
    confere("t1_hab_n", habilita_escrita, 0);
    confere("t1_pronto_a_cheio", pronto_a, 0);
    passo();
    confere("t1_hab", habilita_escrita, 1);
    confere("t1_end", endereco_escrita, 2);
    confere("t1_dado", dado_escrita, 8'h3C);
    confere("t1_pend_n1", pendente, 4'b0100);
    confere("t1_pronto_a_livre", pronto_a, 1);
    passo();
    confere("t1_hab_cai", habilita_escrita, 0);
    confere("t1_pend_zero", pendente, 0);
    confere("t1_banco", banco[2], 8'h3C);

    // idle holds outputs
    repeat (10) passo();
    confere("ocioso_hab", habilita_escrita, 0);
    confere("ocioso_end", endereco_escrita, 2);
    confere("ocioso_dado", dado_escrita, 8'h3C);
    confere("ocioso_pend", pendente, 0);
    confere("ocioso_nwr", wr_n, 1);

    // first conflict on r1: A wins in both configurations
    req_a = 1'b1; end_a = 2'd1; dado_a = 8'h11;
    req_b = 1'b1; end_b = 2'd1; dado_b = 8'h22;
    passo();
    req_a = 1'b0; req_b = 1'b0;
    confere("c1_pend", pendente, 4'b0010);
    confere("c1_prontos", {pronto_a, pronto_b}, 2'b00);
    passo();
    confere("c1_primeiro", dado_escrita, 8'h11);
    confere("c1_prontos_g", {pronto_a, pronto_b}, 2'b10);
    passo();
    confere("c1_segundo", dado_escrita, 8'h22);
    confere("c1_hab2", habilita_escrita, 1);
    passo();
    confere("c1_hab_cai", habilita_escrita, 0);
    confere("c1_banco", banco[1], 8'h22);

    // second conflict: round-robin now favours B
    req_a = 1'b1; dado_a = 8'h33;
    req_b = 1'b1; dado_b = 8'h44;
    passo();
    req_a = 1'b0; req_b = 1'b0;
    passo();
`ifdef ARB_RODIZIO_EN
    confere("c2_primeiro", dado_escrita, 8'h44);
    passo();
    confere("c2_segundo", dado_escrita, 8'h33);
    passo();
    confere("c2_banco", banco[1], 8'h33);
`else
    confere("c2_primeiro", dado_escrita, 8'h33);
    passo();
    confere("c2_segundo", dado_escrita, 8'h44);
    passo();
    confere("c2_banco", banco[1], 8'h44);
`endif

    // B streaming: request held six cycles, data advances on each accepted transfer
    base = wr_n;
    d = 8'h50;
    req_b = 1'b1; end_b = 2'd3; dado_b = d;
    for (int i = 0; i < 6; i++) begin
      confere($sformatf("rajada_pronto_%0d", i), pronto_b, (i % 2 == 0) ? 1 : 0);
      if (pronto_b) begin
        passo();
        d = d + 8'h01;
        dado_b = d;
      end else passo();
    end
    req_b = 1'b0;
    repeat (3) passo();
    confere("rajada_nwr", wr_n - base, 3);
    confere("rajada_w0", wr_log[base[5:0]], 8'h50);
    confere("rajada_w1", wr_log[6'(base + 1)], 8'h51);
    confere("rajada_w2", wr_log[6'(base + 2)], 8'h52);
    confere("rajada_banco", banco[3], 8'h52);

    // reset while a write to r3 is on the bank port
    base = wr_n;
    req_a = 1'b1; end_a = 2'd3; dado_a = 8'hFF;
    passo();
    req_a = 1'b0;
    passo();
    confere("rst_pre_hab", habilita_escrita, 1);
    reset = 1'b0;
    #1;
    confere("rstm_hab", habilita_escrita, 0);
    confere("rstm_pend", pendente, 0);
    confere("rstm_prontos", {pronto_a, pronto_b}, 2'b00);
    confere("rstm_end", endereco_escrita, 0);
    confere("rstm_dado", dado_escrita, 0);
    repeat (2) passo();
    reset = 1'b1;
    repeat (4) passo();
    confere("rstm_nwr", wr_n - base, 0);
    confere("rstm_banco", banco[3], 8'h52);
    confere("rstm_hab_fim", habilita_escrita, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/arbitro_escrita_banco.md
ARBITRO_ESCRITA_BANCO -- requirements
Module: arbitro_escrita_banco

Interface
REQ-001 Parameter LARGURA_DADO, default 8, SHALL set the width of every data path.
REQ-002 Parameter LARGURA_END, default 2, SHALL set the register address width; NREG = 2**LARGURA_END.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-005 req_a, req_b  input  1 each  SHALL be the write-request valid of requester A (ULA writeback) and B (memory load).
REQ-006 end_a, end_b  input  LARGURA_END each  SHALL be the destination register address of each requester.
REQ-007 dado_a, dado_b  input  LARGURA_DADO each  SHALL be the write data of each requester.
REQ-008 pronto_a, pronto_b  output  1 each  SHALL be the ready of each requester; a transfer occurs on a rising edge with req_x=1 and pronto_x=1.
REQ-009 habilita_escrita  output  1  SHALL be the registered write enable to the register bank.
REQ-010 endereco_escrita  output  LARGURA_END  SHALL be the registered write address to the bank.
REQ-011 dado_escrita  output  LARGURA_DADO  SHALL be the registered write data to the bank.
REQ-012 pendente  output  NREG  SHALL flag, per register, a write accepted but not yet committed, for decode stall logic.

Function
REQ-013 Each requester SHALL own a 1-entry buffer (cheio_x, end, dado); a transfer SHALL load it and set cheio_x.
REQ-014 pronto_x SHALL equal (reset=1) AND NOT cheio_x, combinationally.
REQ-015 FSM states OCIOSO, ESCREVE_A, ESCREVE_B SHALL encode which source the registered outputs currently carry.
REQ-016 Each edge: if no buffer full -> OCIOSO, habilita_escrita=0; if exactly one full -> ESCREVE_x; if both full -> arbitration winner per REQ-025/026.
REQ-017 On entering ESCREVE_x, the outputs SHALL take buffer x contents, habilita_escrita=1, and cheio_x SHALL clear on the same edge.
REQ-018 Latency: transfer at edge N -> outputs valid after edge N+1 -> bank commits at edge N+2; one write per cycle aggregate, one per two cycles per requester.
REQ-019 A transfer into a buffer SHALL never occur on the edge it is granted (pronto_x=0 while full), so no data loss.
REQ-020 pendente[r] SHALL be 1 iff a full buffer holds address r, or habilita_escrita=1 with endereco_escrita=r.
REQ-021 Both buffers full with the same address SHALL be written in grant order; the later grant's data is final in the bank.
REQ-022 In OCIOSO, endereco_escrita and dado_escrita SHALL hold their previous values.

Reset
REQ-023 reset=0 SHALL immediately force: state OCIOSO, cheio_a=cheio_b=0, habilita_escrita=0, endereco_escrita=0, dado_escrita=0, pendente=0, pronto_a=pronto_b=0, round-robin pointer to A.
REQ-024 Reset asserted mid-operation SHALL discard buffered and in-flight writes; no bank write SHALL follow reset release without a new transfer.

Configuration
REQ-025 With ARB_RODIZIO_EN defined, both-full conflicts SHALL be granted round-robin: the requester not granted last wins; pointer updates only on a conflict grant.
REQ-026 Without ARB_RODIZIO_EN, requester A SHALL always win conflicts (fixed priority); the pointer register SHALL not exist.

Structure
REQ-027 A shared package SHALL hold the FSM state typedef (OCIOSO, ESCREVE_A, ESCREVE_B) and the default width constants.
REQ-028 The per-requester buffer SHALL be one sub-module, buffer_requisicao, instantiated twice.

Verification
REQ-029 req_a=1, end_a=2, dado_a=8'h3C for one cycle -> habilita_escrita=1, endereco_escrita=2, dado_escrita=8'h3C exactly one cycle after the transfer; pendente=4'b0100 from the transfer edge until habilita_escrita drops.
REQ-030 Both requesters transfer on the same edge (A: r1=8'h11, B: r1=8'h22), ARB_RODIZIO_EN defined -> A written first, then B; bank r1 ends at 8'h22.
REQ-031 Same as REQ-030 repeated twice, without ARB_RODIZIO_EN -> A granted first both times; with it -> second conflict grants B first.
REQ-032 req_b held high for 6 cycles with incrementing data -> pronto_b toggles 1,0,1,0...; exactly 3 writes, none lost or duplicated.
REQ-033 reset=0 one cycle after a transfer of A (r3=8'hFF) -> habilita_escrita=0, pendente=0, pronto_x=0 immediately; no write to r3 after release.
REQ-034 Idle for 10 cycles after a write -> habilita_escrita=0, endereco_escrita/dado_escrita unchanged, pendente=0.
